// File: rtl/nn_pkg.sv
// Shared fixed-point constants and controller state encoding for the neuron
// training datapath and its controllers.
package nn_pkg;

    localparam int BITS = 16;
    localparam int FRAC = 8;

    localparam logic signed [BITS-1:0] MAX_POS = {1'b0, {(BITS-1){1'b1}}};
    localparam logic signed [BITS-1:0] MAX_NEG = {1'b1, {(BITS-1){1'b0}}};

    typedef enum logic [3:0] {
        IDLE,
        FP_RUN,
        FP_CAP,
        GAP,
        BP_RUN,
        BP_CAP,
        UPDATE,
        NEXT,
        DONE
    } state_t;

endpackage

// File: rtl/fxp_mul_sat.sv
// Signed fixed-point multiply: full-width product, rescale by FRAC (floor),
// saturate to the signed BITS range.
module fxp_mul_sat #(
    parameter int BITS = nn_pkg::BITS,
    parameter int FRAC = nn_pkg::FRAC
) (
    input  logic signed [BITS-1:0] a,
    input  logic signed [BITS-1:0] b,
    output logic signed [BITS-1:0] y
);

    localparam int PW = 2 * BITS;

    localparam logic signed [PW-1:0] HI = {{(BITS+1){1'b0}}, {(BITS-1){1'b1}}};
    localparam logic signed [PW-1:0] LO = {{(BITS+1){1'b1}}, {(BITS-1){1'b0}}};

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] scaled;

    always_comb begin
        prod   = PW'(a) * PW'(b);
        scaled = prod >>> FRAC;
        if (scaled > HI) begin
            y = {1'b0, {(BITS-1){1'b1}}};
        end else if (scaled < LO) begin
            y = {1'b1, {(BITS-1){1'b0}}};
        end else begin
            y = scaled[BITS-1:0];
        end
    end

endmodule

// File: rtl/neuron_train_sequencer.sv
// Sequences one sigmoid neuron through FP/BP phases over a sample set for a
// number of epochs, updating its bias and accumulating per-epoch |dZ| error.
module neuron_train_sequencer
    import nn_pkg::*;
#(
    parameter int N           = 2,
    parameter int BITS        = nn_pkg::BITS,
    parameter int FRAC        = nn_pkg::FRAC,
    parameter int FP_CYCLES   = 6,
    parameter int BP_CYCLES   = 6,
    parameter int NUM_SAMPLES = 4,
    parameter int EPOCHS      = 8,
    localparam int SW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1,
    localparam int EW = $clog2(EPOCHS + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [BITS-1:0] lr,
    input  logic [BITS-1:0] b_init,
    output logic            fp,
    output logic            bp,
    output logic [BITS-1:0] b,
    output logic [SW-1:0]   sample_idx,
    input  logic [BITS-1:0] y_in,
    input  logic [BITS-1:0] dz_in,
    output logic [BITS-1:0] y_out,
    output logic            y_valid,
    output logic [BITS+7:0] err_sum,
    output logic [EW-1:0]   epoch,
    output logic            busy,
    output logic            done
);

    localparam int CMAX = (FP_CYCLES > BP_CYCLES) ? FP_CYCLES : BP_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    if (N < 2 || (N % 2) != 0) begin : g_bad_n
        $error("neuron_train_sequencer: N must be even and >= 2");
    end

    state_t state, state_next;

    logic [CW-1:0]   cnt;
    logic [BITS-1:0] lr_q;
    logic [BITS-1:0] dz_q;
    logic [BITS-1:0] prod;
    logic [BITS:0]   diff;
    logic [BITS-1:0] b_upd;
    logic [BITS-1:0] dz_abs;
    logic [BITS+8:0] err_ext;
    logic [BITS+7:0] err_upd;

    logic cnt_zero, last_sample, last_epoch, kill;
    logic ld_start, cap_y, cap_dz, do_update, adv_sample, wrap_epoch, clr_err;

    fxp_mul_sat #(
        .BITS(BITS),
        .FRAC(FRAC)
    ) u_mul (
        .a(lr_q),
        .b(dz_q),
        .y(prod)
    );

    // Bias update and |dZ| accumulation, both saturating.
    always_comb begin
        diff = {b[BITS-1], b} - {prod[BITS-1], prod};
        if (diff[BITS] != diff[BITS-1]) begin
            b_upd = diff[BITS] ? {1'b1, {(BITS-1){1'b0}}} : {1'b0, {(BITS-1){1'b1}}};
        end else begin
            b_upd = diff[BITS-1:0];
        end

        if (!dz_q[BITS-1]) begin
            dz_abs = dz_q;
        end else if (dz_q == {1'b1, {(BITS-1){1'b0}}}) begin
            dz_abs = {1'b0, {(BITS-1){1'b1}}};
        end else begin
            dz_abs = -dz_q;
        end

        err_ext = {1'b0, err_sum} + {9'b0, dz_abs};
        err_upd = err_ext[BITS+8] ? '1 : err_ext[BITS+7:0];
    end

    always_comb begin
        state_next  = state;
        fp          = 1'b0;
        bp          = 1'b0;
        y_valid     = 1'b0;
        done        = 1'b0;
        ld_start    = 1'b0;
        cap_y       = 1'b0;
        cap_dz      = 1'b0;
        do_update   = 1'b0;
        adv_sample  = 1'b0;
        wrap_epoch  = 1'b0;
        clr_err     = 1'b0;
        cnt_zero    = (cnt == '0);
        last_sample = (sample_idx == SW'(NUM_SAMPLES - 1));
        last_epoch  = (epoch == EW'(EPOCHS - 1));
        busy        = (state != IDLE) && (state != DONE);
        kill        = abort && busy;

        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    ld_start   = 1'b1;
                    state_next = FP_RUN;
                end
            end
            FP_RUN: begin
                fp = 1'b1;
                if (cnt_zero) state_next = FP_CAP;
            end
            FP_CAP: begin
                y_valid    = 1'b1;
                cap_y      = 1'b1;
                state_next = GAP;
            end
            GAP: state_next = BP_RUN;
            BP_RUN: begin
                bp = 1'b1;
                if (cnt_zero) state_next = BP_CAP;
            end
            BP_CAP: begin
                cap_dz     = 1'b1;
                state_next = UPDATE;
            end
            UPDATE: begin
                do_update  = 1'b1;
                state_next = NEXT;
            end
            NEXT: begin
                if (!last_sample) begin
                    adv_sample = 1'b1;
                    state_next = FP_RUN;
                end else begin
                    wrap_epoch = 1'b1;
                    if (last_epoch) begin
                        state_next = DONE;
                    end else begin
                        clr_err    = 1'b1;
                        state_next = FP_RUN;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Abort discards every side effect of the current cycle.
        if (kill) begin
            state_next = IDLE;
            y_valid    = 1'b0;
            cap_y      = 1'b0;
            cap_dz     = 1'b0;
            do_update  = 1'b0;
            adv_sample = 1'b0;
            wrap_epoch = 1'b0;
            clr_err    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            lr_q       <= '0;
            dz_q       <= '0;
            b          <= '0;
            sample_idx <= '0;
            y_out      <= '0;
            err_sum    <= '0;
            epoch      <= '0;
        end else begin
            if (state_next == FP_RUN && state != FP_RUN) begin
                cnt <= CW'(FP_CYCLES - 1);
            end else if (state_next == BP_RUN && state != BP_RUN) begin
                cnt <= CW'(BP_CYCLES - 1);
            end else if ((state == FP_RUN || state == BP_RUN) && !cnt_zero) begin
                cnt <= cnt - CW'(1);
            end

            if (ld_start) begin
                lr_q       <= lr;
                b          <= b_init;
                err_sum    <= '0;
                epoch      <= '0;
                sample_idx <= '0;
            end

            if (cap_y)  y_out <= y_in;
            if (cap_dz) dz_q  <= dz_in;

            if (do_update) begin
                b       <= b_upd;
                err_sum <= err_upd;
            end

            if (adv_sample) sample_idx <= sample_idx + SW'(1);
            if (wrap_epoch) begin
                sample_idx <= '0;
                epoch      <= epoch + EW'(1);
            end
            if (clr_err) err_sum <= '0;
        end
    end

endmodule

// File: tb/tb_neuron_train_sequencer.sv
// Directed plus randomized checks of neuron_train_sequencer against a
// cycle-timeline and arithmetic reference model.
module tb_neuron_train_sequencer;

    localparam int S = 4;
    localparam int E = 2;
    localparam int P = 17;
    localparam int T = P * S * E;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [15:0] lr, b_init, y_in, dz_in;
    logic        fp, bp, y_valid, busy, done;
    logic [15:0] b, y_out;
    logic [1:0]  sample_idx;
    logic [23:0] err_sum;
    logic [1:0]  epoch;

    int n_cmp = 0;
    int n_err = 0;
    int cyc_g = 0;
    logic prev_fp = 1'b0;
    logic prev_bp = 1'b0;

    logic [15:0] yv  [S*E];
    logic [15:0] dzv [S*E];
    logic [15:0] prev_y;

    always #5 clk = ~clk;

    neuron_train_sequencer #(
        .N(2),
        .BITS(16),
        .FRAC(8),
        .FP_CYCLES(6),
        .BP_CYCLES(6),
        .NUM_SAMPLES(S),
        .EPOCHS(E)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .lr(lr),
        .b_init(b_init),
        .fp(fp),
        .bp(bp),
        .b(b),
        .sample_idx(sample_idx),
        .y_in(y_in),
        .dz_in(dz_in),
        .y_out(y_out),
        .y_valid(y_valid),
        .err_sum(err_sum),
        .epoch(epoch),
        .busy(busy),
        .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc_g, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_g++;
        chk("fp_bp_exclusive", 32'(fp && bp), 32'd0);
        if (bp && !prev_bp) chk("bp_gap_after_fp", 32'(prev_fp), 32'd0);
        prev_fp = fp;
        prev_bp = bp;
    endtask

    function automatic longint sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_fp"}, 32'(fp), 0);
        chk({tag, "_bp"}, 32'(bp), 0);
        chk({tag, "_b"}, 32'(b), 0);
        chk({tag, "_idx"}, 32'(sample_idx), 0);
        chk({tag, "_yout"}, 32'(y_out), 0);
        chk({tag, "_yvalid"}, 32'(y_valid), 0);
        chk({tag, "_err"}, 32'(err_sum), 0);
        chk({tag, "_epoch"}, 32'(epoch), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask

    // Full run: model computes bias/error after every sample, then the
    // expected waveform is derived from the fixed 17-cycle sample period.
    task automatic run(input logic [15:0] lr_v, input logic [15:0] b0, input bit poke);
        logic [15:0] bexp [S*E];
        logic [31:0] eexp [S*E];
        longint bm, em, p, pr, ad;
        bm = longint'($signed(b0));
        em = 0;
        for (int k = 0; k < S*E; k++) begin
            if (k % S == 0) em = 0;
            p  = longint'($signed(lr_v)) * longint'($signed(dzv[k]));
            pr = sat16(p >>> 8);
            bm = sat16(bm - pr);
            ad = longint'($signed(dzv[k]));
            if (ad < 0) ad = -ad;
            if (ad > 32767) ad = 32767;
            em = em + ad;
            if (em > 24'hFFFFFF) em = 24'hFFFFFF;
            bexp[k] = 16'(bm);
            eexp[k] = 32'(em);
        end

        start = 1'b1; lr = lr_v; b_init = b0; y_in = yv[0]; dz_in = dzv[0];
        tick();
        start = 1'b0;
        for (int c = 1; c <= T + 2; c++) begin
            int k, cp, j;
            if (c <= T) begin
                k  = (c - 1) / P;
                cp = (c - 1) % P;
                j  = k % S;
                if (cp == 0) begin
                    y_in  = yv[k];
                    dz_in = dzv[k];
                end
                chk("fp", 32'(fp), 32'(cp < 6));
                chk("bp", 32'(bp), 32'(cp >= 8 && cp < 14));
                chk("y_valid", 32'(y_valid), 32'(cp == 6));
                chk("busy", 32'(busy), 1);
                chk("done_run", 32'(done), 0);
                chk("sample_idx", 32'(sample_idx), 32'(j));
                chk("epoch", 32'(epoch), 32'(k / S));
                chk("b", 32'(b), 32'((cp == 16) ? bexp[k] : (k > 0 ? bexp[k-1] : b0)));
                chk("err_sum", 32'(err_sum), (cp == 16) ? eexp[k] : (j > 0 ? eexp[k-1] : 32'd0));
                chk("y_out", 32'(y_out), 32'((cp >= 7) ? yv[k] : (k > 0 ? yv[k-1] : prev_y)));
                if (poke && cp == 3) begin
                    start  = 1'b1;
                    lr     = 16'($urandom);
                    b_init = 16'($urandom);
                end else begin
                    start = 1'b0;
                end
            end else begin
                start = 1'b0;
                chk("fp_end", 32'(fp), 0);
                chk("bp_end", 32'(bp), 0);
                chk("busy_end", 32'(busy), 0);
                chk("done_end", 32'(done), 32'(c == T + 1));
                chk("idx_end", 32'(sample_idx), 0);
                chk("epoch_end", 32'(epoch), E);
                chk("b_end", 32'(b), 32'(bexp[S*E-1]));
                chk("err_end", 32'(err_sum), eexp[S*E-1]);
                chk("yout_end", 32'(y_out), 32'(yv[S*E-1]));
            end
            if (c < T + 2) tick();
        end
        prev_y = yv[S*E-1];
    endtask

    task automatic fill(input logic [15:0] dz_const, input bit rand_dz);
        for (int k = 0; k < S*E; k++) begin
            yv[k]  = 16'($urandom);
            dzv[k] = rand_dz ? 16'($urandom) : dz_const;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        lr = '0; b_init = '0; y_in = '0; dz_in = '0;
        prev_y = '0;
        tick();
        tick();
        check_reset("reset");
        rst = 1'b0;
        tick();
        check_reset("idle");

        // abort beats start in IDLE
        abort = 1'b1; start = 1'b1;
        tick();
        chk("abort_start_busy", 32'(busy), 0);
        chk("abort_start_fp", 32'(fp), 0);
        abort = 1'b0; start = 1'b0;
        tick();
        chk("abort_start_busy2", 32'(busy), 0);

        // basic: b goes to 0xFF80 after first update, err 0x0080
        fill(16'h0080, 1'b0);
        run(16'h0100, 16'h0000, 1'b0);

        // negative clamp
        fill(16'h7FFF, 1'b0);
        run(16'h7FFF, 16'h8000, 1'b0);

        // sample walk, err cleared per epoch; start pokes while busy
        fill(16'h0010, 1'b0);
        run(16'h0040, 16'h0123, 1'b1);

        // abort in BP_RUN
        start = 1'b1; lr = 16'h0100; b_init = 16'h0A00; y_in = 16'h1357; dz_in = 16'h0040;
        tick();
        start = 1'b0;
        repeat (10) tick();
        chk("abort_pre_bp", 32'(bp), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_fp", 32'(fp), 0);
        chk("abort_bp", 32'(bp), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_b", 32'(b), 32'h0A00);
        chk("abort_err", 32'(err_sum), 0);
        chk("abort_idx", 32'(sample_idx), 0);
        chk("abort_yout", 32'(y_out), 32'h1357);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("abort_no_done", 32'(done), 0);
            chk("abort_idle", 32'(busy), 0);
        end
        prev_y = 16'h1357;

        fill(16'h0000, 1'b1);
        run(16'($urandom_range(0, 16'h0300)), 16'($urandom), 1'b0);

        // rst during FP_RUN, with start also high
        start = 1'b1; lr = 16'h0100; b_init = 16'h0500; y_in = 16'h2222; dz_in = 16'h0010;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("rst_pre_fp", 32'(fp), 1);
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        check_reset("rst_mid");
        prev_y = '0;
        tick();
        chk("rst_after_busy", 32'(busy), 0);

        for (int r = 0; r < 3; r++) begin
            fill(16'h0000, 1'b1);
            run(16'($urandom), 16'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
